// File: rtl/bus_arbiter_pkg.sv
// Shared types and status decode for the XT bus arbiter.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {CPU_OWN, HANDOVER, DMA_OWN, RELEASE} arbiter_state_t;

  typedef enum logic [2:0] {
    INTA, IO_READ, IO_WRITE, HALT, CODE, MEM_READ, MEM_WRITE, PASSIVE
  } bus_cycle_t;

  localparam logic [2:0] STATUS_PASSIVE = 3'b111;

  // Enumerator order mirrors the 8088 S2..S0 encoding, so the cast is exact.
  function automatic bus_cycle_t decode_status(input logic [2:0] status);
    if (status == STATUS_PASSIVE) return PASSIVE;
    return bus_cycle_t'(status);
  endfunction

endpackage

// File: rtl/ready_wait_counter.sv
// Cycle-start detection, wait-state counting, pending-cycle latch and CPU READY.
module ready_wait_counter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned IO_WAIT_STATES  = 1,
  parameter int unsigned MEM_WAIT_STATES = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  bus_cycle_t cycle,
  input  logic       cpu_own,
  input  logic       io_channel_ready,
  output logic       wait_idle,
  output logic       processor_ready
);

  logic       prev_passive_q, prev_passive_d;
  logic       active_q, active_d;
  logic       pending_q, pending_d;
  logic [2:0] wait_count_q, wait_count_d;
  logic [2:0] load_value;
  logic       cycle_start;

  assign cycle_start = prev_passive_q && (cycle != PASSIVE);

  always_comb begin
    load_value = '0;
    case (cycle)
      INTA, IO_READ, IO_WRITE:   load_value = 3'(IO_WAIT_STATES);
      CODE, MEM_READ, MEM_WRITE: load_value = 3'(MEM_WAIT_STATES);
      default:                   load_value = '0;
    endcase
  end

  always_comb begin
    prev_passive_d = (cycle == PASSIVE);
    active_d       = active_q;
    pending_d      = pending_q && !cpu_own;
    wait_count_d   = wait_count_q;
    if (cycle_start) begin
      active_d     = 1'b1;
      pending_d    = !cpu_own;
      wait_count_d = load_value;
    end else begin
      if (cycle == PASSIVE) active_d = 1'b0;
      // Held while the bus is away; counting resumes on return to CPU ownership.
      if (cpu_own && (wait_count_q != '0)) wait_count_d = wait_count_q - 3'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_passive_q <= 1'b1;
      active_q       <= 1'b0;
      pending_q      <= 1'b0;
      wait_count_q   <= '0;
    end else begin
      prev_passive_q <= prev_passive_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      wait_count_q   <= wait_count_d;
    end
  end

  assign wait_idle = (wait_count_q == '0);

  always_comb begin
    processor_ready = 1'b1;
    if (!wait_idle)                       processor_ready = 1'b0;
    if (active_q && !io_channel_ready)    processor_ready = 1'b0;
    if (pending_q && !cpu_own)            processor_ready = 1'b0;
  end

endmodule

// File: rtl/bus_arbiter.sv
// XT bus ownership sequencer between the 8088 and the 8237, with CPU READY generation.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned IO_WAIT_STATES  = 1,
  parameter int unsigned MEM_WAIT_STATES = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] processor_status,
  input  logic       processor_lock_n,
  input  logic       dma_hold_request,
  input  logic       io_channel_ready,
  output logic       dma_hold_acknowledge,
  output logic       address_enable_n,
  output logic       processor_ready
);

  arbiter_state_t state_q, state_d;
  bus_cycle_t     cycle;
  logic           wait_idle;
  logic           grant_ok;

  assign cycle = decode_status(processor_status);

  // HALT leaves the bus free, so it does not hold off a DMA request.
  assign grant_ok = dma_hold_request && processor_lock_n && wait_idle &&
                    ((cycle == PASSIVE) || (cycle == HALT));

  ready_wait_counter #(
    .IO_WAIT_STATES  (IO_WAIT_STATES),
    .MEM_WAIT_STATES (MEM_WAIT_STATES)
  ) u_ready_wait_counter (
    .clock            (clock),
    .reset            (reset),
    .cycle            (cycle),
    .cpu_own          (state_q == CPU_OWN),
    .io_channel_ready (io_channel_ready),
    .wait_idle        (wait_idle),
    .processor_ready  (processor_ready)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= CPU_OWN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CPU_OWN:  if (grant_ok) state_d = HANDOVER;
      HANDOVER: state_d = dma_hold_request ? DMA_OWN : RELEASE;
      DMA_OWN:  if (!dma_hold_request) state_d = RELEASE;
      RELEASE:  state_d = CPU_OWN;
      default:  state_d = CPU_OWN;
    endcase
  end

  always_comb begin
    dma_hold_acknowledge = 1'b0;
    address_enable_n     = 1'b1;
    unique case (state_q)
      CPU_OWN:  address_enable_n = 1'b0;
      DMA_OWN:  dma_hold_acknowledge = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter with default wait states (IO=1, MEM=0).
module tb_bus_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] processor_status;
  logic       processor_lock_n;
  logic       dma_hold_request;
  logic       io_channel_ready;
  logic       dma_hold_acknowledge;
  logic       address_enable_n;
  logic       processor_ready;

  int total  = 0;
  int passed = 0;

  bus_arbiter #(
    .IO_WAIT_STATES  (1),
    .MEM_WAIT_STATES (0)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .processor_status     (processor_status),
    .processor_lock_n     (processor_lock_n),
    .dma_hold_request     (dma_hold_request),
    .io_channel_ready     (io_channel_ready),
    .dma_hold_acknowledge (dma_hold_acknowledge),
    .address_enable_n     (address_enable_n),
    .processor_ready      (processor_ready)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic observed, input logic expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
  endtask

  task automatic check_bus(input string tag, input logic hlda, input logic aen);
    check({tag, "_hlda"}, dma_hold_acknowledge, hlda);
    check({tag, "_aen"}, address_enable_n, aen);
  endtask

  initial begin
    reset = 1'b1;
    processor_status = 3'b111;
    processor_lock_n = 1'b1;
    dma_hold_request = 1'b0;
    io_channel_ready = 1'b1;
    #3;
    check_bus("reset", 1'b0, 1'b0);
    check("reset_ready", processor_ready, 1'b1);
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    check_bus("idle", 1'b0, 1'b0);
    check("idle_ready", processor_ready, 1'b1);

    // I/O read, one wait state
    processor_status = 3'b001;
    #1;
    check("ior_before_edge", processor_ready, 1'b1);
    tick();
    check("ior_wait", processor_ready, 1'b0);
    processor_status = 3'b111;
    tick();
    check("ior_done", processor_ready, 1'b1);

    // Memory read, zero wait states
    processor_status = 3'b101;
    tick();
    check("memr_0", processor_ready, 1'b1);
    tick();
    check("memr_1", processor_ready, 1'b1);
    processor_status = 3'b111;
    tick();

    // I/O write stretched by IOCHRDY for 3 clocks after the wait state
    processor_status = 3'b010;
    tick();
    check("iow_wait", processor_ready, 1'b0);
    tick();
    io_channel_ready = 1'b0;
    #1;
    check("iow_chrdy_0", processor_ready, 1'b0);
    tick();
    check("iow_chrdy_1", processor_ready, 1'b0);
    tick();
    check("iow_chrdy_2", processor_ready, 1'b0);
    tick();
    io_channel_ready = 1'b1;
    #1;
    check("iow_released", processor_ready, 1'b1);
    processor_status = 3'b111;
    tick();
    check("iow_done", processor_ready, 1'b1);

    // Plain grant and release
    dma_hold_request = 1'b1;
    tick();
    check_bus("grant_n", 1'b0, 1'b1);
    tick();
    check_bus("grant_n1", 1'b1, 1'b1);
    tick();
    check_bus("dma_hold", 1'b1, 1'b1);
    dma_hold_request = 1'b0;
    tick();
    check_bus("release_m", 1'b0, 1'b1);
    tick();
    check_bus("release_m1", 1'b0, 1'b0);

    // LOCK# holds off the grant
    processor_lock_n = 1'b0;
    dma_hold_request = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_bus("locked", 1'b0, 1'b0);
    end
    processor_lock_n = 1'b1;
    tick();
    check_bus("unlock_1", 1'b0, 1'b1);
    tick();
    check_bus("unlock_2", 1'b1, 1'b1);
    dma_hold_request = 1'b0;
    tick();
    tick();
    check_bus("unlock_back", 1'b0, 1'b0);

    // HRQ together with a CPU memory cycle start: the CPU wins
    processor_status = 3'b101;
    dma_hold_request = 1'b1;
    tick();
    check_bus("cpu_wins_0", 1'b0, 1'b0);
    tick();
    check_bus("cpu_wins_1", 1'b0, 1'b0);
    processor_status = 3'b111;
    tick();
    check_bus("after_cycle_n", 1'b0, 1'b1);
    tick();
    check_bus("after_cycle_n1", 1'b1, 1'b1);

    // CPU I/O write issued while DMA owns the bus becomes pending
    processor_status = 3'b010;
    tick();
    check("pend_start", processor_ready, 1'b0);
    tick();
    check("pend_dma", processor_ready, 1'b0);
    dma_hold_request = 1'b0;
    tick();
    check("pend_release", processor_ready, 1'b0);
    check_bus("pend_release", 1'b0, 1'b1);
    tick();
    check("pend_cpu_wait", processor_ready, 1'b0);
    check_bus("pend_cpu", 1'b0, 1'b0);
    tick();
    check("pend_done", processor_ready, 1'b1);
    processor_status = 3'b111;
    tick();

    // Asynchronous reset in the middle of DMA ownership
    dma_hold_request = 1'b1;
    tick();
    tick();
    check_bus("pre_reset_dma", 1'b1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_bus("async_reset", 1'b0, 1'b0);
    check("async_reset_ready", processor_ready, 1'b1);
    dma_hold_request = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check_bus("post_reset", 1'b0, 1'b0);
    check("post_reset_ready", processor_ready, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Sequences ownership of the XT system bus between the 8088 CPU (through its S2..S0 status) and the 8237 DMA controller (HRQ/HLDA). It also generates CPU READY with per-type wait states and the io_channel_ready stretch. It sits inside CHIPSET between the 8288 bus-control logic, the 8237 and the CPU READY input, and drives address_enable_n for the address, data and command buffers.

## Interface
- IO_WAIT_STATES, 1, extra clocks of READY low for I/O and INTA cycles (0..7)
- MEM_WAIT_STATES, 0, extra clocks of READY low for memory and code cycles (0..7)

- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- processor_status  in  3  CPU S2..S0; 3'b111 = passive
- processor_lock_n  in  1  CPU LOCK#; 0 blocks bus grant
- dma_hold_request  in  1  8237 HRQ
- io_channel_ready  in  1  ISA IOCHRDY; 0 stretches the current CPU cycle
- dma_hold_acknowledge  out  1  8237 HLDA
- address_enable_n  out  1  0 = CPU buffers drive bus; 1 = CPU buffers off (handover or DMA)
- processor_ready  out  1  CPU READY

## Operation
- Cycle decode (registered, on passive→active status edge): 000 INTA, 001/010 I/O, 011 HALT, 100/101/110 MEM, 111 PASSIVE.
- A cycle start loads wait_count with IO_WAIT_STATES (INTA/I/O), MEM_WAIT_STATES (MEM) or 0 (HALT).
- processor_ready = 0 when wait_count != 0, or when io_channel_ready = 0 during an active cycle, or when a cycle is pending while arbiter_state != CPU_OWN. Otherwise 1.
- wait_count decrements by 1 per clock while nonzero and state = CPU_OWN. It saturates at 0 and never wraps.
- Arbiter states:
  - CPU_OWN
    - Go to HANDOVER when HRQ = 1, status = 111 this clock, processor_lock_n = 1 and wait_count = 0.
  - HANDOVER
    - address_enable_n = 1, HLDA = 0.
    - Go to DMA_OWN if HRQ is still 1; go to RELEASE if HRQ has dropped.
  - DMA_OWN
    - HLDA = 1, address_enable_n = 1.
    - Go to RELEASE when HRQ = 0.
  - RELEASE
    - HLDA = 0, address_enable_n = 1.
    - Go to CPU_OWN unconditionally.
- Simultaneous events:
  - A CPU cycle start and HRQ in the same clock: the CPU wins, because status is not passive; HRQ waits.
  - HRQ while LOCK# = 0: held off until the lock releases.
  - A CPU cycle started during HANDOVER, DMA_OWN or RELEASE is latched as pending. Its wait_count begins decrementing only on return to CPU_OWN.
- HALT cycles do not block grant.

## Timing
- Reset values: dma_hold_acknowledge = 0, address_enable_n = 0, processor_ready = 1, state = CPU_OWN, wait_count = 0, pending = 0.
- Grant latency:
  - HRQ sampled high in CPU_OWN at edge N.
  - address_enable_n = 1 after edge N; HLDA = 1 after edge N+1.
  - Minimum 2 clocks from HRQ to HLDA.
- Release latency:
  - HRQ sampled low in DMA_OWN at edge M.
  - HLDA = 0 after edge M; address_enable_n = 0 after edge M+1.
- HLDA and CPU buffer enable never overlap: one dead clock each way.
- Ready latency: READY falls on the first edge after the status edge. It stays low for exactly IO_WAIT_STATES or MEM_WAIT_STATES clocks, plus the clocks io_channel_ready is 0.
- A reset asserted mid-DMA or mid-wait forces reset values asynchronously. A pending cycle is discarded.

## Structure
- Shared package `bus_arbiter_pkg`:
  - typedef enum arbiter_state_t {CPU_OWN, HANDOVER, DMA_OWN, RELEASE}
  - typedef enum bus_cycle_t {INTA, IO_READ, IO_WRITE, HALT, CODE, MEM_READ, MEM_WRITE, PASSIVE}
  - constant STATUS_PASSIVE = 3'b111
  - function decoding processor_status to bus_cycle_t
- One sub-module: `ready_wait_counter`. It covers cycle-start detection, wait_count load and decrement, and pending and READY generation. Inputs are the decoded cycle and the state = CPU_OWN qualifier.

## Test plan
- Reset, then idle with status 111 → HLDA 0, address_enable_n 0, READY 1.
- I/O read at status 001, IO_WAIT_STATES = 1 → READY low for exactly 1 clock after the status edge. MEM read at 101, MEM_WAIT_STATES = 0 → READY never falls.
- I/O write with io_channel_ready held 0 for 3 clocks → READY low for 1 + 3 = 4 clocks.
- HRQ = 1 with status 111 and lock_n = 1 → address_enable_n 1 next clock, HLDA 1 the clock after. HRQ = 0 → HLDA 0 next clock, address_enable_n 0 the clock after.
- HRQ = 1 while lock_n = 0 for 5 clocks → HLDA stays 0 until 2 clocks after lock_n rises. HRQ = 1 in the same clock as status 101 → grant only after the cycle returns to 111.
- CPU status 010 issued during DMA_OWN → READY 0 until RELEASE→CPU_OWN, then 1 wait state. Reset pulsed during DMA_OWN → HLDA 0 and address_enable_n 0 immediately.
